// File: rtl/qpsk_symbol_pacer.sv
// Symbol pacer: buffers words in a FIFO and releases one per symbol period, timed
// by a modulo-CLK_FREQ_HZ phase accumulator stepped by the latched symbol rate.
module qpsk_symbol_pacer #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 16,
   parameter int PRIME_LEVEL = 8,
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int ACC_WIDTH   = 33
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [31:0]                   symbol_rate,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          data_valid_in,
   output logic                          in_ready,
   output logic [DATA_WIDTH-1:0]         sym_data,
   output logic                          sym_valid,
   output logic [$clog2(DEPTH):0]        fill_level,
   output logic                          overflow,
   output logic                          underflow,
   output logic                          rate_changed
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [ACC_WIDTH-1:0] MODULUS = ACC_WIDTH'(CLK_FREQ_HZ);
   localparam logic [LW-1:0]        DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0]        PRIME_L = LW'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ACC_WIDTH-1:0]    rate_q;
   logic [ACC_WIDTH-1:0]    rate_in;
   logic [ACC_WIDTH-1:0]    acc;
   logic [ACC_WIDTH-1:0]    sum;
   logic                    rate_upd;
   logic                    tick;
   logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [LW-1:0]           level;
   logic [LW-1:0]           level_next;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    starve;

   // Rates above the clock frequency saturate to one symbol per cycle.
   always_comb begin
      rate_in = ACC_WIDTH'(symbol_rate);
      if ({32'd0, symbol_rate} > 64'(CLK_FREQ_HZ))
         rate_in = MODULUS;
   end

   assign rate_upd = (rate_in != rate_q);
   assign sum      = acc + rate_q;
   // A rate-change cycle restarts the phase, so it never produces a tick.
   assign tick     = enable && !rate_upd && (sum >= MODULUS);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rate_q       <= '0;
         acc          <= '0;
         rate_changed <= 1'b0;
      end else begin
         rate_changed <= rate_upd;
         if (rate_upd)
            rate_q <= rate_in;
         if (!enable || rate_upd)
            acc <= '0;
         else if (sum >= MODULUS)
            acc <= sum - MODULUS;
         else
            acc <= sum;
      end
   end

   assign full  = (level == DEPTH_L);
   assign empty = (level == '0);
   assign push  = data_valid_in && !full;

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      starve     = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (rate_q != '0))
               state_next = PRIME;
         end
         PRIME: begin
            if (level >= PRIME_L)
               state_next = RUN;
         end
         RUN: begin
            if (tick) begin
               if (empty) begin
                  starve     = 1'b1;
                  state_next = PRIME;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (!enable || (rate_q == '0))
         state_next = IDLE;
   end

   always_comb begin
      level_next = level;
      case ({push, pop})
         2'b10:   level_next = level + LW'(1);
         2'b01:   level_next = level - LW'(1);
         default: level_next = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         in_ready  <= 1'b0;
         sym_data  <= '0;
         sym_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_next;
         level     <= level_next;
         in_ready  <= (level_next != DEPTH_L);
         sym_valid <= pop;
         overflow  <= data_valid_in && full;
         underflow <= starve;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            sym_data <= mem[rd_ptr];
         end
      end
   end

   assign fill_level = level;

endmodule

// File: tb/tb_qpsk_symbol_pacer.sv
// Scoreboard bench for qpsk_symbol_pacer: words are queued as they are accepted
// and compared in order against every sym_valid strobe; pacing checked by cycle gaps.
module tb_qpsk_symbol_pacer;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int PRIME = 8;
   localparam int CLKF  = 1000;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [31:0]   symbol_rate;
   logic [DW-1:0] data_in;
   logic          data_valid_in;
   logic          in_ready;
   logic [DW-1:0] sym_data;
   logic          sym_valid;
   logic [4:0]    fill_level;
   logic          overflow;
   logic          underflow;
   logic          rate_changed;

   qpsk_symbol_pacer #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .PRIME_LEVEL (PRIME),
      .CLK_FREQ_HZ (CLKF),
      .ACC_WIDTH   (33)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .symbol_rate   (symbol_rate),
      .data_in       (data_in),
      .data_valid_in (data_valid_in),
      .in_ready      (in_ready),
      .sym_data      (sym_data),
      .sym_valid     (sym_valid),
      .fill_level    (fill_level),
      .overflow      (overflow),
      .underflow     (underflow),
      .rate_changed  (rate_changed)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_miss = 0;
   int            cyc = 0;
   int            last_sv_cyc = 0;
   int            last_gap = 0;
   int            sv_total = 0;
   int            mcount = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_word = '0;
   logic [DW-1:0] next_word = 16'h1000;

   // One clock: model accepts the write, then pops the scoreboard on a strobe.
   task automatic step();
      logic [DW-1:0] exp_word;
      @(posedge clk);
      #1;
      cyc++;
      if (data_valid_in && mcount < DEPTH) begin
         exp_q.push_back(data_in);
         mcount++;
      end
      if (sym_valid) begin
         sv_total++;
         last_gap    = cyc - last_sv_cyc;
         last_sv_cyc = cyc;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_extra: got strobe data %h, expected no strobe", sym_data);
         end else begin
            exp_word  = exp_q.pop_front();
            mcount--;
            last_word = exp_word;
            $display("cycle %0d: symbol %h (gap %0d)", cyc, sym_data, last_gap);
            if (sym_data !== exp_word) begin
               n_miss++;
               $display("FAIL scoreboard_data: got %h expected %h", sym_data, exp_word);
            end
         end
      end
   endtask

   task automatic feed(input int limit);
      if (mcount < limit) begin
         data_valid_in = 1'b1;
         data_in       = next_word;
         next_word++;
      end else begin
         data_valid_in = 1'b0;
      end
   endtask

   task automatic write_one();
      data_valid_in = 1'b1;
      data_in       = next_word;
      next_word++;
      step();
      data_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; symbol_rate = 32'd0;
      data_in = '0; data_valid_in = 1'b0;
      repeat (3) step();
      n_vec++;
      if ({in_ready, sym_valid, overflow, underflow, rate_changed} !== 5'b0) begin
         n_miss++;
         $display("FAIL reset_flags: got %b expected 00000", {in_ready, sym_valid, overflow, underflow, rate_changed});
      end
      n_vec++;
      if (fill_level !== 5'd0) begin n_miss++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
      n_vec++;
      if (sym_data !== '0) begin n_miss++; $display("FAIL reset_data: got %h expected 0", sym_data); end
      #2 reset_n = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_miss++; $display("FAIL release_ready_early: got %b expected 0", in_ready); end
      step();
      n_vec++;
      if (in_ready !== 1'b1) begin n_miss++; $display("FAIL release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) begin
         data_valid_in = 1'b1; data_in = next_word; next_word++;
         step();
         if (i < 16) begin
            n_vec++;
            if (fill_level !== 5'(i + 1)) begin n_miss++; $display("FAIL ovf_fill_%0d: got %0d expected %0d", i, fill_level, i + 1); end
            n_vec++;
            if (in_ready !== logic'(i < 15)) begin n_miss++; $display("FAIL ovf_ready_%0d: got %b expected %b", i, in_ready, logic'(i < 15)); end
         end else begin
            n_vec++;
            if (overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
            n_vec++;
            if (fill_level !== 5'd16) begin n_miss++; $display("FAIL ovf_full: got %0d expected 16", fill_level); end
         end
      end
      data_valid_in = 1'b0;
      step();
      n_vec++;
      if (overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_one_cycle: got %b expected 0", overflow); end
   endtask

   task automatic test_max_rate();
      int start;
      bit got_uf = 0;
      symbol_rate = 32'd5000; enable = 1'b1;
      step();
      n_vec++;
      if (rate_changed !== 1'b1) begin n_miss++; $display("FAIL clamp_rate_changed: got %b expected 1", rate_changed); end
      start = sv_total;
      for (int i = 0; i < 40 && !got_uf; i++) begin
         step();
         if (sym_valid && (sv_total - start) > 1) begin
            n_vec++;
            if (last_gap !== 1) begin n_miss++; $display("FAIL clamp_gap: got %0d expected 1", last_gap); end
         end
         if (underflow) begin
            got_uf = 1;
            n_vec++;
            if (cyc - last_sv_cyc !== 1) begin n_miss++; $display("FAIL clamp_uf_gap: got %0d expected 1", cyc - last_sv_cyc); end
         end
      end
      n_vec++;
      if (!got_uf) begin n_miss++; $display("FAIL clamp_underflow: got none expected pulse within 40 cycles"); end
      n_vec++;
      if (sv_total - start !== 16) begin n_miss++; $display("FAIL clamp_count: got %0d expected 16", sv_total - start); end
      step();
      n_vec++;
      if (underflow !== 1'b0) begin n_miss++; $display("FAIL clamp_uf_one_cycle: got %b expected 0", underflow); end
      n_vec++;
      if (sym_data !== last_word) begin n_miss++; $display("FAIL data_hold: got %h expected %h", sym_data, last_word); end
      enable = 1'b0;
      step();
   endtask

   task automatic test_exact_pacing();
      int start;
      symbol_rate = 32'd250;
      step();
      n_vec++;
      if (rate_changed !== 1'b1) begin n_miss++; $display("FAIL exact_rate_changed: got %b expected 1", rate_changed); end
      repeat (8) write_one();
      n_vec++;
      if (fill_level !== 5'd8) begin n_miss++; $display("FAIL exact_preload: got %0d expected 8", fill_level); end
      enable = 1'b1;
      last_sv_cyc = cyc;
      start = sv_total;
      for (int i = 0; i < 60; i++) begin
         feed(10);
         step();
         if (sym_valid) begin
            n_vec++;
            if (last_gap !== 4) begin n_miss++; $display("FAIL exact_gap: got %0d expected 4", last_gap); end
         end
      end
      data_valid_in = 1'b0;
      n_vec++;
      if (sv_total - start !== 15) begin n_miss++; $display("FAIL exact_count: got %0d expected 15", sv_total - start); end
   endtask

   task automatic test_rate_change();
      int start;
      int fill_exp;
      bit got_uf = 0;
      symbol_rate = 32'd500; data_valid_in = 1'b0;
      fill_exp = mcount;
      step();
      n_vec++;
      if (rate_changed !== 1'b1) begin n_miss++; $display("FAIL rc_pulse: got %b expected 1", rate_changed); end
      n_vec++;
      if (fill_level !== 5'(fill_exp)) begin n_miss++; $display("FAIL rc_fifo_intact: got %0d expected %0d", fill_level, fill_exp); end
      last_sv_cyc = cyc;
      start = sv_total;
      for (int i = 0; i < 60 && !got_uf; i++) begin
         step();
         if (i == 0) begin
            n_vec++;
            if (rate_changed !== 1'b0) begin n_miss++; $display("FAIL rc_one_cycle: got %b expected 0", rate_changed); end
         end
         if (sym_valid) begin
            n_vec++;
            if (last_gap !== 2) begin n_miss++; $display("FAIL rc_gap: got %0d expected 2", last_gap); end
         end
         if (underflow) begin
            got_uf = 1;
            n_vec++;
            if (cyc - last_sv_cyc !== 2) begin n_miss++; $display("FAIL rc_uf_gap: got %0d expected 2", cyc - last_sv_cyc); end
         end
      end
      n_vec++;
      if (!got_uf) begin n_miss++; $display("FAIL rc_underflow: got none expected pulse within 60 cycles"); end
      n_vec++;
      if (sv_total - start !== fill_exp) begin n_miss++; $display("FAIL rc_count: got %0d expected %0d", sv_total - start, fill_exp); end
   endtask

   task automatic test_prime_underflow();
      int start;
      bit got_uf = 0;
      start = sv_total;
      repeat (7) write_one();
      repeat (20) step();
      n_vec++;
      if (sv_total - start !== 0) begin n_miss++; $display("FAIL prime_hold: got %0d strobes expected 0", sv_total - start); end
      n_vec++;
      if (fill_level !== 5'd7) begin n_miss++; $display("FAIL prime_fill: got %0d expected 7", fill_level); end
      write_one();
      for (int i = 0; i < 60 && !got_uf; i++) begin
         step();
         if (sym_valid && (sv_total - start) > 1) begin
            n_vec++;
            if (last_gap !== 2) begin n_miss++; $display("FAIL prime_gap: got %0d expected 2", last_gap); end
         end
         if (underflow) begin
            got_uf = 1;
            n_vec++;
            if (cyc - last_sv_cyc !== 2) begin n_miss++; $display("FAIL prime_uf_gap: got %0d expected 2", cyc - last_sv_cyc); end
         end
      end
      n_vec++;
      if (!got_uf) begin n_miss++; $display("FAIL prime_underflow: got none expected pulse within 60 cycles"); end
      n_vec++;
      if (sv_total - start !== 8) begin n_miss++; $display("FAIL prime_count: got %0d expected 8", sv_total - start); end
      step();
      n_vec++;
      if (underflow !== 1'b0) begin n_miss++; $display("FAIL prime_uf_one_cycle: got %b expected 0", underflow); end
      repeat (7) write_one();
      repeat (20) step();
      n_vec++;
      if (sv_total - start !== 8) begin n_miss++; $display("FAIL reprime_hold: got %0d strobes expected 8", sv_total - start); end
   endtask

   task automatic test_fractional();
      int start;
      int k;
      int exp_gap;
      enable = 1'b0;
      step();
      symbol_rate = 32'd300;
      write_one();
      n_vec++;
      if (rate_changed !== 1'b1) begin n_miss++; $display("FAIL frac_rate_changed: got %b expected 1", rate_changed); end
      n_vec++;
      if (fill_level !== 5'd8) begin n_miss++; $display("FAIL frac_fill: got %0d expected 8", fill_level); end
      enable = 1'b1;
      last_sv_cyc = cyc;
      start = sv_total;
      for (int i = 0; i < 100; i++) begin
         feed(10);
         step();
         if (sym_valid) begin
            k = sv_total - start - 1;
            exp_gap = (k == 0) ? 4 : (((k - 1) % 3 == 2) ? 4 : 3);
            n_vec++;
            if (last_gap !== exp_gap) begin n_miss++; $display("FAIL frac_gap_%0d: got %0d expected %0d", k, last_gap, exp_gap); end
         end
      end
      data_valid_in = 1'b0;
      n_vec++;
      if (sv_total - start !== 30) begin n_miss++; $display("FAIL frac_count: got %0d expected 30", sv_total - start); end
   endtask

   task automatic test_async_reset();
      enable = 1'b0; data_valid_in = 1'b0;
      step();
      for (int i = 0; i < 20 && mcount < 10; i++) write_one();
      step();
      n_vec++;
      if (fill_level !== 5'd10) begin n_miss++; $display("FAIL ar_fill_before: got %0d expected 10", fill_level); end
      n_vec++;
      if (sym_data !== last_word) begin n_miss++; $display("FAIL ar_hold_before: got %h expected %h", sym_data, last_word); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if (fill_level !== 5'd0) begin n_miss++; $display("FAIL ar_fill_immediate: got %0d expected 0", fill_level); end
      n_vec++;
      if (sym_data !== '0) begin n_miss++; $display("FAIL ar_data_immediate: got %h expected 0", sym_data); end
      n_vec++;
      if ({in_ready, sym_valid, overflow, underflow, rate_changed} !== 5'b0) begin
         n_miss++;
         $display("FAIL ar_flags_immediate: got %b expected 00000", {in_ready, sym_valid, overflow, underflow, rate_changed});
      end
      exp_q.delete();
      mcount = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_miss++; $display("FAIL ar_ready_early: got %b expected 0", in_ready); end
      step();
      n_vec++;
      if (in_ready !== 1'b1) begin n_miss++; $display("FAIL ar_ready: got %b expected 1", in_ready); end
      n_vec++;
      if (fill_level !== 5'd0) begin n_miss++; $display("FAIL ar_fill_after: got %0d expected 0", fill_level); end
      n_vec++;
      if (rate_changed !== 1'b1) begin n_miss++; $display("FAIL ar_relatch: got %b expected 1", rate_changed); end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_max_rate();
      test_exact_pacing();
      test_rate_change();
      test_prime_underflow();
      test_fractional();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
